// File: rtl/tone_gen_pkg.sv
// tone_gen_pkg: shared state encoding and default widths for the tone output stage
package tone_gen_pkg;
  localparam int CNT_W_DEF = 20;
  localparam int MIN_HALF_DEF = 2;
  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;
endpackage

// File: rtl/tone_gen_toggle_divider.sv
// toggle_divider: half-period counter that toggles its output at terminal count and resamples the period on each edge
module toggle_divider #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] period_in,
  output logic             q,
  output logic             tc
);
  logic [CNT_W-1:0] cnt, cur;
  assign tc = |cur && (cnt == cur - 1'b1);
  // a zero period parks the output high instead of toggling
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      cur <= '0;
      q <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      cur <= '0;
      q <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      cur <= load_val;
      q <= 1'b1;
    end else if (en && tc) begin
      cnt <= '0;
      cur <= period_in;
      q <= ~q | ~|period_in;
    end else if (en && |cur) begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/tone_gen.sv
// tone_gen: gates octave-scaled periods with the key press to drive a glitch-free speaker square wave and activity LED
module tone_gen
  import tone_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int MIN_HALF = MIN_HALF_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] half_period,
  input  logic [CNT_W-1:0] led_period,
  input  logic             note_on,
  output logic             speaker,
  output logic             led,
  output logic             active
);
  state_t state, nxt;
  logic clr, load, run, spk_tc, led_tc_unused, valid;
  assign valid = half_period >= CNT_W'(MIN_HALF);
  assign active = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  // an edge with a released key or an invalid period ends the note; a low speaker with no key ends it at once
  always_comb begin
    nxt = state;
    clr = 1'b0;
    load = 1'b0;
    run = 1'b0;
    if (state == IDLE) begin
      load = note_on && valid;
      clr = !load;
      nxt = load ? PLAY : IDLE;
    end else if ((spk_tc && (!note_on || !valid)) || (!note_on && !speaker)) begin
      clr = 1'b1;
      nxt = IDLE;
    end else begin
      run = 1'b1;
      nxt = note_on ? PLAY : DRAIN;
    end
  end
  toggle_divider #(.CNT_W(CNT_W)) u_spk (
    .clk(clk), .rst(reset), .clr(clr), .load(load), .en(run),
    .load_val(half_period), .period_in(half_period), .q(speaker), .tc(spk_tc)
  );
  toggle_divider #(.CNT_W(CNT_W)) u_led (
    .clk(clk), .rst(reset), .clr(clr), .load(load), .en(run),
    .load_val(led_period), .period_in(led_period), .q(led), .tc(led_tc_unused)
  );
endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: scoreboard bench for tone_gen against a remaining-cycles reference model
module tb_tone_gen;
  logic clk = 1'b0, reset = 1'b1, note_on = 1'b0, speaker, led, active;
  logic [19:0] half_period = '0, led_period = '0;
  int n_tests = 0, n_fail = 0;
  int m_st, m_srem, m_lrem;
  logic m_spk, m_led;
  logic [2:0] sb[$];
  always #5 clk = ~clk;
  tone_gen dut (
    .clk(clk), .reset(reset), .half_period(half_period), .led_period(led_period),
    .note_on(note_on), .speaker(speaker), .led(led), .active(active)
  );
  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: spk/led/act got %b expected %b", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_srem = 0; m_lrem = 0; m_spk = 1'b0; m_led = 1'b0;
  endtask
  task automatic model(input logic n, input int hp, input int lp);
    logic last;
    if (m_st == 0) begin
      if (n && hp >= 2) begin
        m_st = 1; m_spk = 1'b1; m_srem = hp; m_led = 1'b1; m_lrem = lp;
      end
    end else begin
      last = m_srem == 1;
      if ((last && (!n || hp < 2)) || (!n && !m_spk)) m_st = 0;
      else begin
        if (last) begin m_spk = ~m_spk; m_srem = hp; end
        else m_srem--;
        if (m_lrem == 1) begin m_led = (lp == 0) ? 1'b1 : ~m_led; m_lrem = lp; end
        else if (m_lrem != 0) m_lrem--;
        m_st = n ? 1 : 2;
      end
    end
    if (m_st == 0) begin m_spk = 1'b0; m_led = 1'b0; m_srem = 0; m_lrem = 0; end
  endtask
  task automatic step(input string tag, input logic n, input int hp, input int lp);
    note_on = n; half_period = 20'(hp); led_period = 20'(lp);
    model(n, hp, lp);
    sb.push_back({m_spk, m_led, m_st != 0});
    @(posedge clk); #1;
    check(tag, {speaker, led, active}, sb.pop_front());
  endtask
  task automatic run(input string tag, input int cycles, input logic n, input int hp, input int lp);
    for (int i = 0; i < cycles; i++) step(tag, n, hp, lp);
  endtask
  initial begin
    model_reset();
    #1 check("reset_async", {speaker, led, active}, 3'b000);
    @(posedge clk); #1;
    check("reset_held", {speaker, led, active}, 3'b000);
    reset = 1'b0;
    run("steady", 25, 1'b1, 5, 3);
    run("off1", 10, 1'b0, 5, 3);
    run("mid_a", 12, 1'b1, 5, 3);
    run("mid_b", 14, 1'b1, 3, 3);
    run("off2", 8, 1'b0, 3, 3);
    run("rel_a", 14, 1'b1, 6, 3);
    run("rel_b", 10, 1'b0, 6, 3);
    run("inv0_a", 9, 1'b1, 4, 2);
    run("inv0_b", 8, 1'b1, 0, 2);
    run("inv1_a", 6, 1'b1, 4, 2);
    run("inv1_b", 8, 1'b1, 1, 2);
    run("led3", 25, 1'b1, 10, 3);
    run("led0", 25, 1'b1, 10, 0);
    run("idle", 6, 1'b0, 10, 0);
    run("redo_a", 7, 1'b1, 6, 2);
    run("redo_b", 2, 1'b0, 6, 2);
    run("redo_c", 14, 1'b1, 6, 2);
    run("drain", 4, 1'b0, 6, 2);
    run("rst_a", 3, 1'b1, 8, 2);
    run("rst_b", 2, 1'b0, 8, 2);
    #2 reset = 1'b1;
    #1 check("rst_mid_drain", {speaker, led, active}, 3'b000);
    sb.delete();
    model_reset();
    @(posedge clk); #1;
    check("rst_hold", {speaker, led, active}, 3'b000);
    reset = 1'b0;
    run("after_rst", 20, 1'b1, 4, 3);
    for (int i = 0; i < 300; i++)
      step("random", $urandom_range(0, 5) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
